// File: rtl/uart_pkg.sv
// Shared UART constants: default TX FIFO depth, data width and pointer/level width.
package uart_pkg;

   localparam int UART_TX_FIFO_DEPTH = 16;
   localparam int UART_DATA_WIDTH    = 8;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   localparam int UART_TX_FIFO_PW = ptr_width(UART_TX_FIFO_DEPTH);

endpackage

// File: rtl/uart_fifo_mem.sv
// 1-write/1-read register file for the UART TX FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_TX_FIFO_DEPTH,
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   localparam int AW        = $clog2(DEPTH)
)(
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through TX FIFO feeding uart_tx, with sticky overflow flag.
// Define UART_TX_FIFO_THRESH_EN to compile in the low-watermark compare on thresh_irq_o.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH      = UART_TX_FIFO_DEPTH,
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   localparam int AW        = $clog2(DEPTH),
   localparam int PW        = ptr_width(DEPTH)
)(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  wr_valid_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   output logic                  wr_ready_o,
   output logic [DATA_WIDTH-1:0] tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic [PW-1:0]         level_o,
   output logic                  overflow_o,
   input  logic                  ovf_clr_i,
   input  logic [PW-1:0]         thresh_i,
   output logic                  thresh_irq_o
);

   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [PW-1:0] level_q;
   logic          ovf_q;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;

   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
   assign empty = (wptr_q == rptr_q);

   // Full blocks the push even when a pop frees a slot in the same cycle.
   assign push = wr_valid_i && !full;
   assign pop  = !empty && tx_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else if (clr_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + PW'(1);
            2'b01:   level_q <= level_q - PW'(1);
            default: level_q <= level_q;
         endcase
         // A fresh overflow wins over a clear request in the same cycle.
         if (wr_valid_i && full) ovf_q <= 1'b1;
         else if (ovf_clr_i)     ovf_q <= 1'b0;
      end
   end

   uart_fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push && !clr_i),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (wr_data_i),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (tx_data_o)
   );

   assign wr_ready_o = !full;
   assign tx_valid_o = (level_q != '0);
   assign level_o    = level_q;
   assign overflow_o = ovf_q;

`ifdef UART_TX_FIFO_THRESH_EN
   assign thresh_irq_o = (level_q <= thresh_i);
`else
   logic unused_thresh;
   assign unused_thresh = ^thresh_i;
   assign thresh_irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized plus directed bench for uart_tx_fifo against a queue-based model of the FIFO.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int PW    = 5;

`ifdef UART_TX_FIFO_THRESH_EN
   localparam bit THR_ON = 1'b1;
`else
   localparam bit THR_ON = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          clr_i = 1'b0;
   logic          wr_valid_i = 1'b0;
   logic [DW-1:0] wr_data_i = '0;
   logic          wr_ready_o;
   logic [DW-1:0] tx_data_o;
   logic          tx_valid_o;
   logic          tx_ready_i = 1'b0;
   logic [PW-1:0] level_o;
   logic          overflow_o;
   logic          ovf_clr_i = 1'b0;
   logic [PW-1:0] thresh_i = '0;
   logic          thresh_irq_o;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mq [$];
   bit            m_ovf = 1'b0;

   uart_tx_fifo dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clr_i        (clr_i),
      .wr_valid_i   (wr_valid_i),
      .wr_data_i    (wr_data_i),
      .wr_ready_o   (wr_ready_o),
      .tx_data_o    (tx_data_o),
      .tx_valid_o   (tx_valid_o),
      .tx_ready_i   (tx_ready_i),
      .level_o      (level_o),
      .overflow_o   (overflow_o),
      .ovf_clr_i    (ovf_clr_i),
      .thresh_i     (thresh_i),
      .thresh_irq_o (thresh_irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: FIFO as a queue, updated from the inputs seen at each rising edge.
   always @(posedge clk_i) begin
      if (rst_i) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (clr_i) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         bit was_full;
         was_full = (mq.size() == DEPTH);
         if (mq.size() != 0 && tx_ready_i) void'(mq.pop_front());
         if (wr_valid_i && !was_full) mq.push_back(wr_data_i);
         if (wr_valid_i && was_full) m_ovf = 1'b1;
         else if (ovf_clr_i)         m_ovf = 1'b0;
      end
   end

   always @(negedge clk_i) begin
      int sz;
      sz = rst_i ? 0 : mq.size();
      chk("level",      int'(level_o),      sz);
      chk("tx_valid",   int'(tx_valid_o),   int'(sz != 0));
      chk("wr_ready",   int'(wr_ready_o),   int'(sz != DEPTH));
      chk("overflow",   int'(overflow_o),   rst_i ? 0 : int'(m_ovf));
      chk("thresh_irq", int'(thresh_irq_o), THR_ON ? int'(sz <= int'(thresh_i)) : 0);
      if (sz != 0) chk("tx_data", int'(tx_data_o), int'(mq[0]));
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      // reset state
      @(negedge clk_i);
      chk("rst_tx_valid", int'(tx_valid_o), 0);
      chk("rst_wr_ready", int'(wr_ready_o), 1);
      chk("rst_level", int'(level_o), 0);
      chk("rst_overflow", int'(overflow_o), 0);
      chk("rst_thresh_irq", int'(thresh_irq_o), THR_ON ? 1 : 0);
      tick();
      rst_i = 1'b0;
      tick();

      // single push, FWFT
      wr_valid_i = 1'b1; wr_data_i = 8'h41;
      tick();
      wr_valid_i = 1'b0;
      @(negedge clk_i);
      chk("push41_valid", int'(tx_valid_o), 1);
      chk("push41_data", int'(tx_data_o), 'h41);
      chk("push41_level", int'(level_o), 1);
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;

      // fill, overflow, ordered drain
      wr_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data_i = DW'(i);
         tick();
      end
      wr_data_i = 8'hAA;
      @(negedge clk_i);
      chk("full_wr_ready", int'(wr_ready_o), 0);
      chk("full_level", int'(level_o), 16);
      tick();
      wr_valid_i = 1'b0;
      @(negedge clk_i);
      chk("ovf_set", int'(overflow_o), 1);
      chk("ovf_level", int'(level_o), 16);
      tx_ready_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk("drain_order", int'(tx_data_o), i);
         tick();
         @(negedge clk_i);
      end
      tx_ready_i = 1'b0;
      chk("drained_level", int'(level_o), 0);
      chk("ovf_sticky", int'(overflow_o), 1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      @(negedge clk_i);
      chk("ovf_cleared", int'(overflow_o), 0);

      // full with simultaneous push and pop
      wr_valid_i = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data_i = DW'(8'h20 + i);
         tick();
      end
      wr_data_i = 8'hBB; tx_ready_i = 1'b1;
      tick();
      wr_valid_i = 1'b0; tx_ready_i = 1'b0;
      @(negedge clk_i);
      chk("fullpp_level", int'(level_o), 15);
      chk("fullpp_head", int'(tx_data_o), 'h21);
      chk("fullpp_ovf", int'(overflow_o), 1);
      tx_ready_i = 1'b1;
      repeat (7) tick();
      tx_ready_i = 1'b0;
      @(negedge clk_i);
      chk("lvl8", int'(level_o), 8);

      // clear overrides a push
      clr_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'hCC;
      tick();
      clr_i = 1'b0; wr_valid_i = 1'b0;
      @(negedge clk_i);
      chk("clr_level", int'(level_o), 0);
      chk("clr_valid", int'(tx_valid_o), 0);
      chk("clr_ovf", int'(overflow_o), 0);

      // steady level 5 under push+pop
      wr_valid_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wr_data_i = DW'(8'h50 + k);
         tick();
      end
      tx_ready_i = 1'b1;
      for (int j = 0; j < 10; j++) begin
         wr_data_i = DW'(8'h55 + j);
         tick();
         @(negedge clk_i);
         chk("pp5_level", int'(level_o), 5);
         chk("pp5_head", int'(tx_data_o), 'h51 + j);
      end
      wr_valid_i = 1'b0;
      repeat (5) tick();
      tx_ready_i = 1'b0;

      // watermark
      wr_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wr_data_i = DW'(8'h60 + k);
         tick();
      end
      wr_valid_i = 1'b0; thresh_i = PW'(2);
      @(negedge clk_i);
      chk("thr_lvl3", int'(thresh_irq_o), 0);
      tx_ready_i = 1'b1;
      tick();
      tx_ready_i = 1'b0;
      @(negedge clk_i);
      chk("thr_lvl2_level", int'(level_o), 2);
      chk("thr_lvl2", int'(thresh_irq_o), THR_ON ? 1 : 0);
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;

      // reset mid-transfer drops tx_valid at once
      wr_valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wr_data_i = DW'(8'h70 + k);
         tick();
      end
      wr_valid_i = 1'b0;
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      chk("midrst_valid", int'(tx_valid_o), 0);
      chk("midrst_level", int'(level_o), 0);
      chk("midrst_wr_ready", int'(wr_ready_o), 1);
      tick();
      rst_i = 1'b0;

      // randomized traffic with phases biased toward full and toward empty
      for (int c = 0; c < 4000; c++) begin
         int pw;
         int pr;
         pw = ((c / 400) % 2 == 0) ? 80 : 30;
         pr = ((c / 400) % 2 == 0) ? 30 : 80;
         wr_valid_i = ($urandom_range(99) < pw);
         tx_ready_i = ($urandom_range(99) < pr);
         wr_data_i  = DW'($urandom);
         clr_i      = ($urandom_range(127) == 0);
         ovf_clr_i  = ($urandom_range(15) == 0);
         thresh_i   = PW'($urandom_range(DEPTH));
         rst_i      = ($urandom_range(699) == 0);
         tick();
      end

      wr_valid_i = 1'b0; tx_ready_i = 1'b0; clr_i = 1'b0;
      ovf_clr_i = 1'b0; rst_i = 1'b0;
      repeat (3) tick();
      @(negedge clk_i);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per entry; matches uart_tx data width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; ports clk_i and rst_i.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 clr_i  input  1  synchronous flush of all entries.
REQ-007 wr_valid_i  input  1  bus-side push request.
REQ-008 wr_data_i  input  DATA_WIDTH  push data.
REQ-009 wr_ready_o  output  1  push accepted when high; equals not-full.
REQ-010 tx_data_o  output  DATA_WIDTH  head entry; drives uart_tx tx_data_i.
REQ-011 tx_valid_o  output  1  head entry valid; drives uart_tx tx_valid_i.
REQ-012 tx_ready_i  input  1  pop acknowledge; driven by uart_tx tx_ready_o.
REQ-013 level_o  output  log2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-014 overflow_o  output  1  sticky: a push was dropped while full.
REQ-015 ovf_clr_i  input  1  clears overflow_o.
REQ-016 thresh_i  input  log2(DEPTH)+1  low-watermark level.
REQ-017 thresh_irq_o  output  1  level is at or below the watermark.

Function
REQ-018 Push SHALL occur when wr_valid_i and wr_ready_o are both high; data is written at the write pointer, which then increments.
REQ-019 Pop SHALL occur when tx_valid_o and tx_ready_i are both high; the read pointer then increments.
REQ-020 Read side SHALL be first-word-fall-through: tx_data_o is the entry at the read pointer whenever tx_valid_o is high; push-to-tx_valid_o latency is 1 cycle from empty.
REQ-021 tx_valid_o SHALL equal (level != 0); tx_data_o SHALL be held stable until popped.
REQ-022 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full is indicated when addresses are equal and MSBs differ; empty when the pointers are equal.
REQ-023 level_o SHALL be a registered value: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-024 When full, wr_ready_o SHALL be low even if a pop occurs in the same cycle; the push is dropped.
REQ-025 A push attempt while full SHALL set overflow_o on the next cycle; overflow_o holds until ovf_clr_i, clr_i or rst_i.
REQ-026 If ovf_clr_i and a new overflow occur in the same cycle, overflow_o SHALL remain set.
REQ-027 When empty, a pop SHALL be impossible, because tx_valid_o is low; tx_ready_i is then ignored.
REQ-028 clr_i SHALL zero both pointers, level_o and overflow_o on the next cycle, and SHALL override any push or pop in the same cycle.
REQ-029 Storage contents SHALL NOT be reset; only pointers, level and flags are reset.

Reset
REQ-030 While rst_i is high: pointers = 0, level_o = 0, tx_valid_o = 0, wr_ready_o = 1, overflow_o = 0, thresh_irq_o = 0 (watermark feature off) or 1 (on, since 0 <= thresh_i).
REQ-031 Reset asserted mid-transfer SHALL discard all entries; uart_tx sees tx_valid_o low immediately.

Configuration
REQ-032 Macro UART_TX_FIFO_THRESH_EN SHALL compile in the watermark compare.
REQ-033 With the macro defined, thresh_irq_o SHALL equal (level_o <= thresh_i), taken combinationally from the registered level.
REQ-034 Without the macro, thresh_irq_o SHALL be tied 0 and thresh_i SHALL be unused; ports remain present.

Structure
REQ-035 Shared package uart_pkg SHALL hold UART_TX_FIFO_DEPTH (16), UART_DATA_WIDTH (8) and the pointer/level width constant.
REQ-036 Storage SHALL be a sub-module uart_fifo_mem: 1-write/1-read register file, synchronous write, asynchronous read, no reset.
REQ-037 Pointer, level and flag logic SHALL reside in uart_tx_fifo.

Verification
REQ-038 Push 0x41 into an empty FIFO with tx_ready_i low -> tx_valid_o=1 and tx_data_o=0x41 the next cycle, level_o=1.
REQ-039 Push 16 bytes 0x00..0x0F, then a 17th byte 0xAA -> wr_ready_o=0 after the 16th push, 0xAA dropped, overflow_o=1, level_o=16; after popping all entries, the output order is 0x00..0x0F.
REQ-040 Full FIFO with simultaneous push and pop -> push rejected, level_o=15.
REQ-041 level_o=5 with simultaneous push and pop for 10 cycles -> level_o stays 5 and data order is preserved.
REQ-042 level_o=8 with clr_i plus a push in the same cycle -> level_o=0, tx_valid_o=0, overflow_o=0 next cycle.
REQ-043 Macro on, thresh_i=2, pop from level 3 to 2 -> thresh_irq_o rises in the same cycle level_o reads 2; macro off -> thresh_irq_o stays 0.
